// File: rtl/i2c_target.sv
// i2c_target: I2C responder for a single 7-bit bus address. Exposes an
// 8-bit-addressed register space to the fabric through reg_we / reg_re strobes.
// SCL and SDA are oversampled on clk; pad buffering lives above this block.
// Build option: define I2C_TARGET_AUTOINC_EN to advance reg_addr after every
// written byte and every loaded read byte (8'hFF wraps to 8'h00).
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h21
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t     state;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_hist;
    logic       sda_hist;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       load_p1;

    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic byte_done;
    logic addr_match;

    assign scl        = scl_sync[1];
    assign sda        = sda_sync[1];
    assign scl_rise   = scl & ~scl_hist;
    assign scl_fall   = ~scl & scl_hist;
    assign start_det  = scl & scl_hist & sda_hist & ~sda;
    assign stop_det   = scl & scl_hist & ~sda_hist & sda;
    assign byte_done  = scl_fall && (bit_cnt == 4'd8);
    // General call (7'h00) is never acknowledged, even if TARGET_ADDR is zero.
    assign addr_match = (shift[7:1] == TARGET_ADDR) && (shift[7:1] != 7'h00);

    // Two-flop synchronizers plus one history flop per line; an idle bus reads high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    // Protocol FSM: bit shifting, ACK and read-data drive on SDA, register strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            shift     <= 8'h00;
            bit_cnt   <= 4'd0;
            rw        <= 1'b0;
            load_p1   <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            load_p1 <= reg_re;
            // Read data is captured one cycle after the request cycle.
            if (load_p1) begin
                shift <= reg_rdata;
            end
`ifdef I2C_TARGET_AUTOINC_EN
            if (reg_we || load_p1) begin
                reg_addr <= reg_addr + 8'd1;
            end
`endif
            if (stop_det) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_det) begin
                state   <= ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                unique case (state)
                    ADDR, REG, WDATA: begin
                        if (scl_rise && (bit_cnt < 4'd8)) begin
                            shift   <= {shift[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR) begin
                                if (addr_match) begin
                                    state  <= ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                    rw     <= shift[0];
                                end else begin
                                    state <= IGNORE;
                                    busy  <= 1'b0;
                                end
                            end else if (state == REG) begin
                                reg_addr <= shift;
                                sda_oe   <= 1'b1;
                                state    <= REG_ACK;
                            end else begin
                                reg_wdata <= shift;
                                reg_we    <= 1'b1;
                                sda_oe    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_rise && rw) begin
                            reg_re <= 1'b1;
                        end else if (scl_fall) begin
                            if (rw) begin
                                sda_oe  <= ~shift[7];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= 4'd1;
                                state   <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= REG;
                            end
                        end
                    end
                    REG_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= RDATA_ACK;
                            end else begin
                                sda_oe  <= ~shift[7];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda) begin
                                state <= IGNORE;
                            end else begin
                                reg_re <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            sda_oe  <= ~shift[7];
                            shift   <= {shift[6:0], 1'b0};
                            bit_cnt <= 4'd1;
                            state   <= RDATA;
                        end
                    end
                    IDLE, IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller driving i2c_target, with a
// transaction-level register model (pointer + expected write list).
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    always #5 clk = ~clk;

    assign sda_bus   = sda_drv & ~sda_oe;
    assign reg_rdata = reg_addr + 8'h80;

    i2c_target dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (scl_drv),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wr_got[$];
    wr_t        wr_exp[$];
    logic [7:0] wbuf[$];
    logic [7:0] ptr_m = 8'h00;
    int         re_cnt = 0;
    int         oe_cnt = 0;
    int         busy_cnt = 0;
    int         overlap_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    // Observe strobes and line activity away from the active clock edge.
    always @(negedge clk) begin
        if (reg_we) wr_got.push_back({reg_addr, reg_wdata});
        if (reg_re) re_cnt++;
        if (reg_we && reg_re) overlap_cnt++;
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    function automatic logic [7:0] next_ptr(input logic [7:0] p);
`ifdef I2C_TARGET_AUTOINC_EN
        return p + 8'd1;
`else
        return p;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; scl_drv = 1'b1; tick(8);
        sda_drv = 1'b0; tick(8);
        scl_drv = 1'b0;
    endtask

    task automatic bus_rstart();
        tick(4); sda_drv = 1'b1;
        tick(4); scl_drv = 1'b1;
        tick(8); sda_drv = 1'b0;
        tick(8); scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        tick(4); sda_drv = 1'b0;
        tick(4); scl_drv = 1'b1;
        tick(8); sda_drv = 1'b1;
        tick(8);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        tick(4); sda_drv = b;
        tick(4); scl_drv = 1'b1;
        tick(4); r = sda_bus;
        tick(4); scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            b[i] = r;
        end
        bus_bit(nack, r);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_got.size()), 32'(wr_exp.size()));
        for (int i = 0; i < wr_exp.size() && i < wr_got.size(); i++) begin
            check({tag, "_waddr"}, 32'(wr_got[i].a), 32'(wr_exp[i].a));
            check({tag, "_wdata"}, 32'(wr_got[i].d), 32'(wr_exp[i].d));
        end
        wr_got.delete();
        wr_exp.delete();
    endtask

    // Write transaction: dev address, pointer byte, then every byte in wbuf.
    task automatic do_write(input logic [6:0] dev, input logic [7:0] ra);
        logic ack;
        logic hit;
        int   oe0, busy0, re0;
        wr_t  e;
        hit   = (dev == 7'h21);
        oe0   = oe_cnt;
        busy0 = busy_cnt;
        re0   = re_cnt;
        bus_start();
        send_byte({dev, 1'b0}, ack);
        check("addr_ack", 32'(ack), hit ? 0 : 1);
        if (hit) check("busy_set", 32'(busy), 1);
        send_byte(ra, ack);
        check("reg_ack", 32'(ack), hit ? 0 : 1);
        if (hit) ptr_m = ra;
        foreach (wbuf[i]) begin
            send_byte(wbuf[i], ack);
            check("wdata_ack", 32'(ack), hit ? 0 : 1);
            if (hit) begin
                e.a = ptr_m;
                e.d = wbuf[i];
                wr_exp.push_back(e);
                ptr_m = next_ptr(ptr_m);
            end
        end
        bus_stop();
        tick(4);
        check("busy_clr", 32'(busy), 0);
        check("reg_addr", 32'(reg_addr), 32'(ptr_m));
        check("no_read", re_cnt - re0, 0);
        if (!hit) begin
            check("oe_idle", oe_cnt - oe0, 0);
            check("busy_idle", busy_cnt - busy0, 0);
        end
        check_writes("wr");
    endtask

    // Pointer write, repeated start, then n read bytes (last one NACKed).
    task automatic do_read(input logic [7:0] ra, input int n);
        logic       ack;
        logic [7:0] b;
        int         re0;
        bus_start();
        send_byte(8'h42, ack);
        check("rd_addr_ack", 32'(ack), 0);
        send_byte(ra, ack);
        check("rd_reg_ack", 32'(ack), 0);
        ptr_m = ra;
        re0 = re_cnt;
        bus_rstart();
        send_byte(8'h43, ack);
        check("rd_addr2_ack", 32'(ack), 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            check("rd_data", 32'(b), 32'(8'(ptr_m + 8'h80)));
            ptr_m = next_ptr(ptr_m);
        end
        tick(4);
        check("rd_release", 32'(sda_oe), 0);
        bus_stop();
        tick(4);
        check("busy_clr", 32'(busy), 0);
        check("reg_addr", 32'(reg_addr), 32'(ptr_m));
        check("re_count", re_cnt - re0, n);
        check_writes("rd");
    endtask

    initial begin
        logic       ack;
        logic       r;
        logic [6:0] dev;
        int         kind;

        reset_n = 1'b0;
        tick(4);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_reg_we", 32'(reg_we), 0);
        check("rst_reg_re", 32'(reg_re), 0);
        check("rst_reg_addr", 32'(reg_addr), 0);
        check("rst_reg_wdata", 32'(reg_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick(4);

        // Single write, burst write across the wrap, read, mismatch, general call.
        wbuf = '{8'hA5};
        do_write(7'h21, 8'h10);
        wbuf = '{8'h11, 8'h22, 8'h33};
        do_write(7'h21, 8'hFE);
        do_read(8'h05, 2);
        wbuf = '{8'h55, 8'h66};
        do_write(7'h22, 8'h10);
        wbuf = '{8'h77};
        do_write(7'h00, 8'h10);

        // Repeated start during bit 4 of a data byte, then a good transaction.
        bus_start();
        send_byte(8'h42, ack);
        send_byte(8'h30, ack);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
        bus_rstart();
        tick(2);
        check("abort_sda_oe", 32'(sda_oe), 0);
        check("abort_no_we", 32'(wr_got.size()), 0);
        send_byte(8'h42, ack);
        check("abort_addr_ack", 32'(ack), 0);
        send_byte(8'h31, ack);
        send_byte(8'h77, ack);
        check("abort_wdata_ack", 32'(ack), 0);
        wr_exp.push_back({8'h31, 8'h77});
        ptr_m = next_ptr(8'h31);
        bus_stop();
        tick(4);
        check("abort_reg_addr", 32'(reg_addr), 32'(ptr_m));
        check_writes("abort");

        // Reset during bit 4 of a data byte.
        bus_start();
        send_byte(8'h42, ack);
        send_byte(8'h40, ack);
        for (int i = 0; i < 4; i++) bus_bit(1'b0, r);
        #1 reset_n = 1'b0;
        #1 check("rstab_sda_oe", 32'(sda_oe), 0);
        tick(2);
        reset_n = 1'b1;
        ptr_m = 8'h00;
        check("rstab_reg_addr", 32'(reg_addr), 0);
        check("rstab_busy", 32'(busy), 0);
        check_writes("rstab");
        bus_stop();

        // Reset while the target is actively pulling SDA low in a read byte.
        bus_start();
        send_byte(8'h42, ack);
        send_byte(8'h00, ack);
        bus_rstart();
        send_byte(8'h43, ack);
        bus_bit(1'b1, r);
        check("rdrv_bit7", 32'(r), 1);
        tick(6);
        check("rdrv_pull", 32'(sda_oe), 1);
        #1 reset_n = 1'b0;
        #1 check("rdrv_async_clr", 32'(sda_oe), 0);
        tick(2);
        reset_n = 1'b1;
        ptr_m = 8'h00;
        bus_stop();
        wbuf = '{8'hC3};
        do_write(7'h21, 8'h20);
        do_read(8'h20, 1);

        // Randomized mix of writes, reads and foreign addresses.
        for (int t = 0; t < 16; t++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                wbuf.delete();
                repeat ($urandom_range(1, 4)) wbuf.push_back(8'($urandom));
                do_write(7'h21, 8'($urandom));
            end else if (kind == 1) begin
                do_read(8'($urandom), int'($urandom_range(1, 3)));
            end else begin
                dev = 7'($urandom);
                if (dev == 7'h21) dev = 7'h00;
                wbuf = '{8'($urandom)};
                do_write(dev, 8'($urandom));
            end
        end

        check("we_re_overlap", overlap_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
